// File: rtl/pdata_pkg.sv
// Shared opcode, FSM-state and serial bit-order definitions for the serial data PE family.
package pdata_pkg;

  localparam logic [2:0] OP_LOAD_D1  = 3'd0;
  localparam logic [2:0] OP_LOAD_D2  = 3'd1;
  localparam logic [2:0] OP_LOAD_ACC = 3'd2;
  localparam logic [2:0] OP_OUT_D1   = 3'd3;
  localparam logic [2:0] OP_OUT_ACC  = 3'd4;
  localparam logic [2:0] OP_MUL      = 3'd5;
  localparam logic [2:0] OP_MUL_ADD  = 3'd6;
  localparam logic [2:0] OP_CLR      = 3'd7;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd2;
  localparam logic [2:0] ST_MULT      = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  // Serial bus word order: bit 0 travels first on both rx and tx.
  localparam bit SER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/pdata_seqmul.sv
// Iterative SIZE x SIZE unsigned shift-add multiplier; operands captured on start, SIZE iterations.
// done marks the final iteration cycle, when product already carries the finished result.
module pdata_seqmul #(
  parameter int SIZE = 32
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                start,
  input  logic [SIZE-1:0]     a,
  input  logic [SIZE-1:0]     b,
  output logic                busy,
  output logic [2*SIZE-1:0]   product,
  output logic                done
);

  localparam int CW = $clog2(SIZE + 1);

  logic [2*SIZE-1:0] mcand;
  logic [SIZE-1:0]   mplier;
  logic [2*SIZE-1:0] prod;
  logic [2*SIZE-1:0] prod_nxt;
  logic [CW-1:0]     cnt;

  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CW'(SIZE - 1));
  assign product  = prod_nxt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{SIZE{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pdata_mac.sv
// Bit-serial MAC PE; loads/outputs done at N+1 cycles after accept, MUL/MUL_ADD at SIZE+1, CLR at 1.
// cmd_ready only in IDLE (host holds cmd_valid); build option PDATA_MAC_SAT_EN saturates acc on MUL_ADD overflow.
module pdata_mac
  import pdata_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int ACC_W = 128
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  output logic       cmd_ready,
  input  logic       rx,
  output logic       tx,
  output logic       tx_valid,
  output logic       done,
  output logic       ovf
);

  localparam int CNT_W = $clog2(ACC_W + 1);

`ifdef PDATA_MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [2:0]        state;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [SIZE-1:0]   data_1;
  logic [SIZE-1:0]   data_2;
  logic [ACC_W-1:0]  acc;
  logic              ovf_q;

  logic              accept;
  logic              is_acc_op;
  logic [CNT_W-1:0]  last_idx;
  logic              shift_last;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [2*SIZE-1:0] mul_prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    mac_sum;
  logic [ACC_W-1:0]  mac_res;

  logic [SIZE-1:0]   d1_shin, d2_shin, d1_rot;
  logic [ACC_W-1:0]  acc_shin, acc_rot;
  logic              d1_out_bit, acc_out_bit;

  assign cmd_ready  = (state == ST_IDLE) && !mul_busy;
  assign accept     = cmd_valid && cmd_ready;
  assign is_acc_op  = (op_q == OP_LOAD_ACC) || (op_q == OP_OUT_ACC);
  assign last_idx   = is_acc_op ? CNT_W'(ACC_W - 1) : CNT_W'(SIZE - 1);
  assign shift_last = (cnt == last_idx);
  assign mul_start  = accept && ((cmd_op == OP_MUL) || (cmd_op == OP_MUL_ADD));

  pdata_seqmul #(.SIZE(SIZE)) u_mul (
    .clk     (clk),
    .nRst    (nRst),
    .start   (mul_start),
    .a       (data_1),
    .b       (data_2),
    .busy    (mul_busy),
    .product (mul_prod),
    .done    (mul_done)
  );

  always_comb begin
    prod_ext = '0;
    prod_ext[2*SIZE-1:0] = mul_prod;
  end

  assign mac_sum = {1'b0, acc} + {1'b0, prod_ext};
  assign mac_res = (SAT_EN && mac_sum[ACC_W]) ? '1 : mac_sum[ACC_W-1:0];

  // Shift-in fills from the far end so the first wire bit lands at the near end.
  always_comb begin
    if (SER_LSB_FIRST) begin
      d1_shin     = {rx, data_1[SIZE-1:1]};
      d2_shin     = {rx, data_2[SIZE-1:1]};
      acc_shin    = {rx, acc[ACC_W-1:1]};
      d1_rot      = {data_1[0], data_1[SIZE-1:1]};
      acc_rot     = {acc[0], acc[ACC_W-1:1]};
      d1_out_bit  = data_1[0];
      acc_out_bit = acc[0];
    end else begin
      d1_shin     = {data_1[SIZE-2:0], rx};
      d2_shin     = {data_2[SIZE-2:0], rx};
      acc_shin    = {acc[ACC_W-2:0], rx};
      d1_rot      = {data_1[SIZE-2:0], data_1[SIZE-1]};
      acc_rot     = {acc[ACC_W-2:0], acc[ACC_W-1]};
      d1_out_bit  = data_1[SIZE-1];
      acc_out_bit = acc[ACC_W-1];
    end
  end

  assign tx_valid = (state == ST_SHIFT_OUT);
  assign tx       = tx_valid && ((op_q == OP_OUT_ACC) ? acc_out_bit : d1_out_bit);
  assign done     = (state == ST_FINISH);
  assign ovf      = ovf_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= ST_IDLE;
      op_q  <= OP_LOAD_D1;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_q <= cmd_op;
          cnt  <= '0;
          case (cmd_op)
            OP_LOAD_D1, OP_LOAD_D2, OP_LOAD_ACC: state <= ST_SHIFT_IN;
            OP_OUT_D1, OP_OUT_ACC:               state <= ST_SHIFT_OUT;
            OP_MUL, OP_MUL_ADD:                  state <= ST_MULT;
            default:                             state <= ST_FINISH;
          endcase
        end
        ST_SHIFT_IN, ST_SHIFT_OUT: begin
          cnt <= cnt + CNT_W'(1);
          if (shift_last) state <= ST_FINISH;
        end
        ST_MULT:   if (mul_done) state <= ST_FINISH;
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      data_1 <= '0;
      data_2 <= '0;
      acc    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept && (cmd_op == OP_CLR)) begin
          acc   <= '0;
          ovf_q <= 1'b0;
        end
        ST_SHIFT_IN: case (op_q)
          OP_LOAD_D1:  data_1 <= d1_shin;
          OP_LOAD_D2:  data_2 <= d2_shin;
          OP_LOAD_ACC: acc    <= acc_shin;
          default: ;
        endcase
        ST_SHIFT_OUT: case (op_q)
          OP_OUT_D1:  data_1 <= d1_rot;
          OP_OUT_ACC: acc    <= acc_rot;
          default: ;
        endcase
        ST_MULT: if (mul_done) begin
          if (op_q == OP_MUL) begin
            acc <= prod_ext;
          end else begin
            acc <= mac_res;
            if (mac_sum[ACC_W]) ovf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdata_mac.sv
// Directed bench for pdata_mac (SIZE=32, ACC_W=128): loads, reads, MUL/MUL_ADD, CLR, overflow and reset abort.
module tb_pdata_mac;
  import pdata_pkg::*;

  localparam int SIZE  = 32;
  localparam int ACC_W = 128;

`ifdef PDATA_MAC_SAT_EN
  localparam logic [ACC_W-1:0] OVF1_ACC = '1;
  localparam logic [ACC_W-1:0] OVF2_ACC = '1;
`else
  localparam logic [ACC_W-1:0] OVF1_ACC = 128'd3;
  localparam logic [ACC_W-1:0] OVF2_ACC = 128'hFFFF_FFFE_0000_0000;
`endif

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic       rx = 1'b0;
  logic       cmd_ready, tx, tx_valid, done, ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pdata_mac #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .rx        (rx),
    .tx        (tx),
    .tx_valid  (tx_valid),
    .done      (done),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
  task automatic issue(input logic [2:0] op);
    int w = 0;
    while (!cmd_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("issue_ready", 128'(cmd_ready), 128'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic ld(input logic [2:0] op, input int n, input logic [ACC_W-1:0] val, output logic fin);
    issue(op);
    for (int i = 0; i < n; i++) begin
      rx = val[i];
      @(negedge clk);
    end
    rx  = 1'b0;
    fin = done;
  endtask

  task automatic rd(input logic [2:0] op, input int n, output logic [ACC_W-1:0] v,
                    output int nv, output logic fin);
    issue(op);
    v  = '0;
    nv = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_valid) nv++;
      v[i] = tx;
      @(negedge clk);
    end
    fin = done && !tx_valid;
  endtask

  task automatic run(input logic [2:0] op, output int lat);
    issue(op);
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    logic [ACC_W-1:0] v;
    int nv, lat, rdy_n, done_n, both_n;
    logic fin, rdy_seen;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 128'({cmd_ready, tx, tx_valid, done, ovf}), 128'd16);
    nRst = 1'b1;
    @(negedge clk);

    // 3 * 5, then two non-destructive reads of acc
    ld(OP_LOAD_D1, SIZE, 128'd3, fin);
    chk("load_d1_done", 128'(fin), 128'd1);
    ld(OP_LOAD_D2, SIZE, 128'd5, fin);
    run(OP_MUL, lat);
    chk("mul_latency", 128'(lat), 128'(SIZE + 1));
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("out_acc_15", v, 128'd15);
    chk("out_acc_nvalid", 128'(nv), 128'(ACC_W));
    chk("out_acc_done", 128'(fin), 128'd1);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("out_acc_15_again", v, 128'd15);

    run(OP_MUL_ADD, lat);
    chk("madd_latency", 128'(lat), 128'(SIZE + 1));
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("madd_acc_30", v, 128'd30);
    chk("madd_ovf_0", 128'(ovf), 128'd0);
    rd(OP_OUT_D1, SIZE, v, nv, fin);
    chk("out_d1_3", v, 128'd3);
    chk("out_d1_nvalid", 128'(nv), 128'(SIZE));
    rd(OP_OUT_D1, SIZE, v, nv, fin);
    chk("out_d1_3_again", v, 128'd3);

    // all-ones acc + 2*2 overflows
    ld(OP_LOAD_ACC, ACC_W, '1, fin);
    chk("load_acc_done", 128'(fin), 128'd1);
    ld(OP_LOAD_D1, SIZE, 128'd2, fin);
    ld(OP_LOAD_D2, SIZE, 128'd2, fin);
    run(OP_MUL_ADD, lat);
    @(negedge clk);
    chk("ovf_set", 128'(ovf), 128'd1);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("ovf_acc", v, OVF1_ACC);
    run(OP_MUL, lat);
    @(negedge clk);
    chk("ovf_sticky_mul", 128'(ovf), 128'd1);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("mul_overwrites_acc", v, 128'd4);
    run(OP_CLR, lat);
    chk("clr_latency", 128'(lat), 128'd1);
    @(negedge clk);
    chk("clr_ovf", 128'(ovf), 128'd0);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("clr_acc", v, 128'd0);

    // CLR held on cmd_valid: alternating accept / done cycles
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    rdy_n = 0; done_n = 0; both_n = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (cmd_ready) rdy_n++;
      if (done) done_n++;
      if (cmd_ready && done) both_n++;
    end
    cmd_valid = 1'b0;
    chk("held_clr_ready_cycles", 128'(rdy_n), 128'd10);
    chk("held_clr_dones", 128'(done_n), 128'd11);
    chk("held_clr_overlap", 128'(both_n), 128'd0);
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'd0);

    // a pending CLR is not accepted during MULT
    issue(OP_MUL);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    lat = 1;
    rdy_seen = 1'b0;
    while (!done && lat < 200) begin
      rdy_seen |= cmd_ready;
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    chk("busy_latency", 128'(lat), 128'(SIZE + 1));
    chk("busy_not_ready", 128'(rdy_seen), 128'd0);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("busy_clr_ignored", v, 128'd4);

    // max operands, overflow again, then reset mid-MUL
    ld(OP_LOAD_D1, SIZE, 128'hFFFF_FFFF, fin);
    ld(OP_LOAD_D2, SIZE, 128'hFFFF_FFFF, fin);
    ld(OP_LOAD_ACC, ACC_W, '1, fin);
    run(OP_MUL_ADD, lat);
    @(negedge clk);
    chk("ovf2_set", 128'(ovf), 128'd1);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("ovf2_acc", v, OVF2_ACC);
    issue(OP_MUL);
    repeat (SIZE / 2 - 1) @(negedge clk);
    nRst = 1'b0;
    #1;
    chk("abort_outputs", 128'({cmd_ready, tx, tx_valid, done, ovf}), 128'd16);
    chk("abort_state", 128'(dut.state), 128'(ST_IDLE));
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 128'(cmd_ready), 128'd1);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("abort_acc", v, 128'd0);
    rd(OP_OUT_D1, SIZE, v, nv, fin);
    chk("abort_d1", v, 128'd0);

    ld(OP_LOAD_D1, SIZE, 128'hFFFF_FFFF, fin);
    ld(OP_LOAD_D2, SIZE, 128'hFFFF_FFFF, fin);
    run(OP_MUL, lat);
    rd(OP_OUT_ACC, ACC_W, v, nv, fin);
    chk("mul_max", v, 128'hFFFF_FFFE_0000_0001);
    chk("mul_max_ovf", 128'(ovf), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
